// File: rtl/frame_update_sequencer.sv
// frame_update_sequencer
// Hands the shared per-frame "update slot" to NUMBER_OF_CLIENTS game modules
// in fixed order on every rising edge of startOfFrame. Each client holds a
// one-hot grant until it signals done or runs out of time. After the last
// client, frame_done pulses for one cycle.
//
// Optional feature: define FRAME_DIVIDER_EN to start a sequence only on every
// FRAME_DIVIDE-th idle frame edge. Without it, every idle edge starts one.
//
// Handshake: update_req[i] is a registered one-hot grant. update_done[i] is
// only looked at while update_req[i] is high. A done seen in cycle m moves
// the grant to the next client in cycle m+1, with no gap cycle.
module frame_update_sequencer #(
    parameter int NUMBER_OF_CLIENTS = 4,
    parameter int TIMEOUT_CYCLES    = 4096,
    parameter int COUNT_WIDTH       = 16,
    parameter int FRAME_DIVIDE      = 1
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         startOfFrame,
    input  logic [NUMBER_OF_CLIENTS-1:0] update_done,
    output logic [NUMBER_OF_CLIENTS-1:0] update_req,
    output logic                         busy,
    output logic                         frame_done,
    output logic [COUNT_WIDTH-1:0]       frame_count,
    output logic [COUNT_WIDTH-1:0]       overrun_count,
    output logic [NUMBER_OF_CLIENTS-1:0] timeout_flags
);

    localparam int IDX_W = (NUMBER_OF_CLIENTS > 1) ? $clog2(NUMBER_OF_CLIENTS) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUMBER_OF_CLIENTS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUMBER_OF_CLIENTS-1:0] REQ_FIRST = NUMBER_OF_CLIENTS'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]                   state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [TMR_W-1:0]             timer_q, timer_d;
    logic                         sof_q;
    logic [NUMBER_OF_CLIENTS-1:0] req_q, req_d;
    logic                         busy_q, busy_d;
    logic                         fdone_q, fdone_d;
    logic [COUNT_WIDTH-1:0]       fcount_q, fcount_d;
    logic [COUNT_WIDTH-1:0]       ocount_q, ocount_d;
    logic [NUMBER_OF_CLIENTS-1:0] tflags_q, tflags_d;

    logic sof_rise;
    logic done_sel;
    logic start_ok;
    logic overrun_hit;

    // sof_q holds the previous startOfFrame level; it resets low, so a level
    // already high at reset release reads as a rise in the first cycle.
    assign sof_rise = startOfFrame & ~sof_q;
    assign done_sel = update_done[idx_q];

`ifdef FRAME_DIVIDER_EN
    localparam int DIV_W = $clog2(FRAME_DIVIDE) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIVIDE - 1);

    logic [DIV_W-1:0] div_q, div_d;

    assign start_ok = (div_q == DIV_LAST);

    // Divider counts idle frame edges only; edges while busy are overruns.
    always_comb begin
        div_d = div_q;
        if (state_q == ST_IDLE && sof_rise) begin
            if (start_ok) begin
                div_d = '0;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    // Divider register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end
`else
    // Divider compiled out: every idle edge starts a sequence.
    assign start_ok = (FRAME_DIVIDE >= 1);
`endif

    // Next-state and registered-output logic for the sequencing FSM.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        req_d       = req_q;
        busy_d      = busy_q;
        fdone_d     = 1'b0;
        fcount_d    = fcount_q;
        tflags_d    = tflags_q;
        overrun_hit = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_d  = '0;
                busy_d = 1'b0;
                if (sof_rise && start_ok) begin
                    state_d = ST_GRANT;
                    idx_d   = '0;
                    timer_d = '0;
                    req_d   = REQ_FIRST;
                    busy_d  = 1'b1;
                end
            end

            ST_GRANT: begin
                overrun_hit = sof_rise;
                busy_d      = 1'b1;
                timer_d     = timer_q + 1'b1;
                // A done in the final timeout cycle wins: no flag is set.
                if (done_sel || (timer_q == TMR_LAST)) begin
                    if (!done_sel) begin
                        tflags_d[idx_q] = 1'b1;
                    end
                    if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + 1'b1;
                        timer_d = '0;
                        req_d   = REQ_FIRST << (idx_q + 1'b1);
                    end else begin
                        state_d  = ST_DONE;
                        req_d    = '0;
                        fdone_d  = 1'b1;
                        fcount_d = fcount_q + 1'b1;
                    end
                end
            end

            ST_DONE: begin
                // An edge arriving here is an overrun and never starts a sequence.
                overrun_hit = sof_rise;
                state_d     = ST_IDLE;
                req_d       = '0;
                busy_d      = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                timer_d = '0;
                req_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Overrun counter saturates at all-ones.
    always_comb begin
        ocount_d = ocount_q;
        if (overrun_hit && (ocount_q != {COUNT_WIDTH{1'b1}})) begin
            ocount_d = ocount_q + 1'b1;
        end
    end

    // State and output registers; reset drops every output immediately.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            timer_q  <= '0;
            sof_q    <= 1'b0;
            req_q    <= '0;
            busy_q   <= 1'b0;
            fdone_q  <= 1'b0;
            fcount_q <= '0;
            ocount_q <= '0;
            tflags_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            sof_q    <= startOfFrame;
            req_q    <= req_d;
            busy_q   <= busy_d;
            fdone_q  <= fdone_d;
            fcount_q <= fcount_d;
            ocount_q <= ocount_d;
            tflags_q <= tflags_d;
        end
    end

    assign update_req    = req_q;
    assign busy          = busy_q;
    assign frame_done    = fdone_q;
    assign frame_count   = fcount_q;
    assign overrun_count = ocount_q;
    assign timeout_flags = tflags_q;

endmodule

// File: tb/tb_frame_update_sequencer.sv
// Directed bench for frame_update_sequencer. Instance a uses an 8-cycle
// timeout, instance b the default timeout for the long stall, and with
// FRAME_DIVIDER_EN defined instance c runs with FRAME_DIVIDE=3.
module tb_frame_update_sequencer;

    logic        clk;
    logic        resetN;

    logic        sof_a;
    logic [3:0]  done_a;
    logic [3:0]  req_a;
    logic        busy_a;
    logic        fdone_a;
    logic [15:0] fcount_a;
    logic [15:0] ocount_a;
    logic [3:0]  tflags_a;

    logic        sof_b;
    logic [3:0]  done_b;
    logic [3:0]  req_b;
    logic        busy_b;
    logic        fdone_b;
    logic [15:0] fcount_b;
    logic [15:0] ocount_b;
    logic [3:0]  tflags_b;

    int n_cmp;
    int n_err;

    frame_update_sequencer #(
        .NUMBER_OF_CLIENTS(4), .TIMEOUT_CYCLES(8), .COUNT_WIDTH(16)
    ) dut_a (
        .clk(clk), .resetN(resetN), .startOfFrame(sof_a), .update_done(done_a),
        .update_req(req_a), .busy(busy_a), .frame_done(fdone_a),
        .frame_count(fcount_a), .overrun_count(ocount_a), .timeout_flags(tflags_a)
    );

    frame_update_sequencer #(
        .NUMBER_OF_CLIENTS(4), .TIMEOUT_CYCLES(4096), .COUNT_WIDTH(16)
    ) dut_b (
        .clk(clk), .resetN(resetN), .startOfFrame(sof_b), .update_done(done_b),
        .update_req(req_b), .busy(busy_b), .frame_done(fdone_b),
        .frame_count(fcount_b), .overrun_count(ocount_b), .timeout_flags(tflags_b)
    );

`ifdef FRAME_DIVIDER_EN
    logic        sof_c;
    logic [3:0]  done_c;
    logic [3:0]  req_c;
    logic        busy_c;
    logic        fdone_c;
    logic [15:0] fcount_c;
    logic [15:0] ocount_c;
    logic [3:0]  tflags_c;

    frame_update_sequencer #(
        .NUMBER_OF_CLIENTS(4), .TIMEOUT_CYCLES(8), .COUNT_WIDTH(16), .FRAME_DIVIDE(3)
    ) dut_c (
        .clk(clk), .resetN(resetN), .startOfFrame(sof_c), .update_done(done_c),
        .update_req(req_c), .busy(busy_c), .frame_done(fdone_c),
        .frame_count(fcount_c), .overrun_count(ocount_c), .timeout_flags(tflags_c)
    );
`endif

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; sample and drive 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle startOfFrame pulse on instance a / b.
    task automatic pulse_a();
        sof_a = 1'b1;
        tick();
        sof_a = 1'b0;
    endtask

    task automatic pulse_b();
        sof_b = 1'b1;
        tick();
        sof_b = 1'b0;
    endtask

    // Every remaining client answers on its first grant cycle; ends in IDLE.
    task automatic finish_a(input string tag);
        int n;
        n = 0;
        while (!fdone_a && n < 40) begin
            done_a = req_a;
            tick();
            n++;
        end
        done_a = 4'b0000;
        check_val(tag, fdone_a, 1);
        tick();
    endtask

    task automatic finish_b(input string tag);
        int n;
        n = 0;
        while (!fdone_b && n < 40) begin
            done_b = req_b;
            tick();
            n++;
        end
        done_b = 4'b0000;
        check_val(tag, fdone_b, 1);
        tick();
    endtask

`ifdef FRAME_DIVIDER_EN
    task automatic finish_c(input string tag);
        int n;
        n = 0;
        while (!fdone_c && n < 40) begin
            done_c = req_c;
            tick();
            n++;
        end
        done_c = 4'b0000;
        check_val(tag, fdone_c, 1);
        tick();
    endtask
`endif

    initial begin
        int n;
        n_cmp  = 0;
        n_err  = 0;
        resetN = 1'b0;
        sof_a  = 1'b0;
        done_a = 4'b0000;
        sof_b  = 1'b0;
        done_b = 4'b0000;
`ifdef FRAME_DIVIDER_EN
        sof_c  = 1'b0;
        done_c = 4'b0000;
`endif

        // Reset state
        #23;
        check_val("rst_req",    req_a,    0);
        check_val("rst_busy",   busy_a,   0);
        check_val("rst_fdone",  fdone_a,  0);
        check_val("rst_fcount", fcount_a, 0);
        check_val("rst_ocount", ocount_a, 0);
        check_val("rst_tflags", tflags_a, 0);
        tick();
        resetN = 1'b1;
        tick();

        // Ideal handshake: done one cycle after each req rises
        pulse_a();
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("ideal_req%0d_c0", i), req_a, 32'd1 << i);
            check_val($sformatf("ideal_fdone%0d", i), fdone_a, 0);
            check_val($sformatf("ideal_busy%0d", i), busy_a, 1);
            tick();
            check_val($sformatf("ideal_req%0d_c1", i), req_a, 32'd1 << i);
            done_a = 4'b0001 << i;
            tick();
            done_a = 4'b0000;
        end
        check_val("ideal_fdone",  fdone_a,  1);
        check_val("ideal_req_done", req_a,  0);
        check_val("ideal_busy_done", busy_a, 1);
        check_val("ideal_fcount", fcount_a, 1);
        tick();
        check_val("ideal_fdone_off", fdone_a, 0);
        check_val("ideal_busy_off",  busy_a,  0);
        check_val("ideal_tflags",    tflags_a, 0);

        // Timeout: client 1 never answers
        pulse_a();
        check_val("to_req0", req_a, 4'b0001);
        done_a = 4'b0001;
        tick();
        done_a = 4'b0000;
        n = 0;
        while (req_a == 4'b0010 && n < 20) begin
            n++;
            tick();
        end
        check_val("to_hold_cycles", n, 8);
        check_val("to_req2", req_a, 4'b0100);
        check_val("to_tflags", tflags_a, 4'b0010);
        done_a = 4'b0100;
        tick();
        check_val("to_req3", req_a, 4'b1000);
        done_a = 4'b1000;
        tick();
        done_a = 4'b0000;
        check_val("to_fdone", fdone_a, 1);
        check_val("to_fcount", fcount_a, 2);
        tick();

        // Done on the last timeout cycle; stray done[3] during client 0
        pulse_a();
        done_a = 4'b1000;
        for (int k = 0; k < 7; k++) begin
            check_val($sformatf("coinc_hold%0d", k), req_a, 4'b0001);
            tick();
        end
        check_val("coinc_hold7", req_a, 4'b0001);
        done_a = 4'b1001;
        tick();
        done_a = 4'b0000;
        check_val("coinc_req1", req_a, 4'b0010);
        check_val("coinc_tflags", tflags_a, 4'b0010);
        finish_a("coinc_finish");
        check_val("coinc_fcount", fcount_a, 3);

        // Asynchronous reset while client 2 holds the slot
        pulse_a();
        done_a = 4'b0001;
        tick();
        done_a = 4'b0010;
        tick();
        done_a = 4'b0000;
        check_val("arst_pre_req", req_a, 4'b0100);
        #2;
        resetN = 1'b0;
        #1;
        check_val("arst_req",    req_a,    0);
        check_val("arst_busy",   busy_a,   0);
        check_val("arst_fdone",  fdone_a,  0);
        check_val("arst_fcount", fcount_a, 0);
        check_val("arst_tflags", tflags_a, 0);
        tick();
        resetN = 1'b1;
        tick();
        pulse_a();
        check_val("arst_restart_req", req_a, 4'b0001);
        finish_a("arst_finish");
        check_val("arst_fcount_after", fcount_a, 1);

        // Overrun: client 0 stalls 100 cycles, three edges during the stall
        pulse_b();
        check_val("ovr_req0", req_b, 4'b0001);
        for (int c = 0; c < 100; c++) begin
            sof_b = (c == 10 || c == 30 || c == 50);
            tick();
        end
        sof_b = 1'b0;
        check_val("ovr_req_stall", req_b, 4'b0001);
        check_val("ovr_count3", ocount_b, 3);
        finish_b("ovr_finish");
        check_val("ovr_fcount", fcount_b, 1);
        for (int c = 0; c < 5; c++) tick();
        check_val("ovr_no_queue_req", req_b, 0);
        check_val("ovr_no_queue_busy", busy_b, 0);
        check_val("ovr_fcount_still", fcount_b, 1);

        // Edge in the DONE cycle counts as overrun and starts nothing
        pulse_b();
        for (int i = 0; i < 4; i++) begin
            done_b = 4'b0001 << i;
            tick();
        end
        done_b = 4'b0000;
        check_val("ovr_done_fdone", fdone_b, 1);
        sof_b = 1'b1;
        tick();
        sof_b = 1'b0;
        check_val("ovr_done_req", req_b, 0);
        check_val("ovr_done_busy", busy_b, 0);
        check_val("ovr_done_count", ocount_b, 4);
        check_val("ovr_done_fcount", fcount_b, 2);
        tick();
        check_val("ovr_done_req_later", req_b, 0);

`ifdef FRAME_DIVIDER_EN
        // Divide by 3: sequences start on pulses 3 and 6 only
        for (int p = 1; p <= 6; p++) begin
            sof_c = 1'b1;
            tick();
            sof_c = 1'b0;
            check_val($sformatf("div_req_p%0d", p), req_c, (p % 3 == 0) ? 1 : 0);
            if (p % 3 == 0) begin
                finish_c($sformatf("div_finish_p%0d", p));
            end else begin
                tick();
                tick();
            end
        end
        check_val("div_fcount", fcount_c, 2);
        check_val("div_ocount", ocount_c, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/frame_update_sequencer.md
Name: frame_update_sequencer

Overview:
- Schedules per-frame game-logic updates against the video timing.
- On each start of frame, grants the shared "update slot" to NUMBER_OF_CLIENTS game modules in fixed order, one at a time, with a req/done handshake. Typical clients are player, aliens, missiles and score.
- Guarantees object positions change only between frames, then flags frame completion.
- Sits beside video_unit and consumes its startOfFrame output.

Parameters:
- NUMBER_OF_CLIENTS, 4, number of sequenced update clients (1..16).
- TIMEOUT_CYCLES, 4096, max cycles a client may hold the grant before being skipped (>=2).
- COUNT_WIDTH, 16, width of the frame and overrun counters.
- FRAME_DIVIDE, 1, run a sequence every FRAME_DIVIDE-th frame; only used with FRAME_DIVIDER_EN (>=1).

Ports:
- clk  in  1  system clock, single clock domain.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  frame marker from video_unit; level or pulse, rising edge is used.
- update_done  in  NUMBER_OF_CLIENTS  per-client completion; bit i is valid only while update_req[i]=1.
- update_req  out  NUMBER_OF_CLIENTS  one-hot grant; bit i high while client i owns the slot.
- busy  out  1  sequence in progress.
- frame_done  out  1  one-cycle pulse after the last client finishes or is skipped.
- frame_count  out  COUNT_WIDTH  number of completed sequences; wraps.
- overrun_count  out  COUNT_WIDTH  startOfFrame edges seen while busy; saturates at all-ones.
- timeout_flags  out  NUMBER_OF_CLIENTS  sticky; bit i set when client i timed out.

Behaviour:
- Reset: asynchronous; every output and internal register goes to 0, state=IDLE, idx=0.
- Edge detect: sof_d registers startOfFrame. sof_rise = startOfFrame & ~sof_d. sof_d resets to 0, so startOfFrame already high at reset release gives a rise on the first cycle.
- State IDLE:
  - On sof_rise: go to GRANT, set idx=0, clear timer.
  - update_req=0, busy=0.
- State GRANT (registered outputs):
  - update_req = 1<<idx; busy=1.
  - timer increments each cycle.
  - update_done[idx]=1 → advance. Bits of update_done other than idx are ignored.
  - Otherwise timer == TIMEOUT_CYCLES-1 → set timeout_flags[idx], then advance.
- Advance (done and timeout in the same cycle count as done; no flag is set):
  - If idx < NUMBER_OF_CLIENTS-1: idx+1, timer=0, stay in GRANT. update_req moves to the next bit on the next cycle, with no gap cycle.
  - Else: go to DONE.
- State DONE (one cycle):
  - frame_done=1, update_req=0, busy=1, frame_count+1 (wraps).
  - Next state IDLE.
- Latency:
  - sof_rise in cycle n → update_req[0] high in cycle n+1.
  - Client done in cycle m → next grant in cycle m+1.
  - Minimum sequence, every client done on its first grant cycle: NUMBER_OF_CLIENTS+1 cycles from first grant to the end of the frame_done pulse.
- Overrun:
  - sof_rise while in GRANT or DONE: overrun_count+1, saturating; the sequence is neither restarted nor queued.
  - A sof_rise in the same cycle as DONE→IDLE is also an overrun and does not start a sequence.
- timeout_flags is cleared only by reset.
- Reset mid-sequence: outputs drop to 0 immediately, asynchronously. Clients must tolerate update_req falling without a done.

Optional Feature:
- Macro FRAME_DIVIDER_EN.
- Defined:
  - A divider counter (width clog2(FRAME_DIVIDE)+1) counts sof_rise events seen in IDLE.
  - A sequence starts only when the counter equals FRAME_DIVIDE-1; the counter then resets to 0.
  - sof_rise events seen while busy go to overrun_count and do not advance the divider.
- Undefined: every IDLE sof_rise starts a sequence (equivalent to FRAME_DIVIDE=1).

Test Plan:
- Reset and ideal handshake:
  - Stimulus: reset, then one startOfFrame pulse; each client returns done one cycle after its req rises.
  - Required: update_req = 0001, 0010, 0100, 1000, each held 2 cycles; frame_done pulses once; frame_count=1; busy low afterwards.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8; client 1 never asserts done.
  - Required: update_req[1] high exactly 8 cycles; timeout_flags=0010; clients 2 and 3 still granted; frame_done pulses.
- Overrun:
  - Stimulus: client 0 stalls 100 cycles; 3 startOfFrame pulses arrive during the stall.
  - Required: overrun_count=3; only one sequence runs; frame_count=1.
- Asynchronous reset mid-sequence:
  - Stimulus: assert resetN low while update_req=0100, off a clock edge.
  - Required: all outputs 0 without waiting for a clock edge; after release, the next startOfFrame restarts at client 0.
- Done/timeout coincidence and stray done:
  - Stimulus: done arrives exactly on the last timeout cycle; update_done[3] held high while idx=0.
  - Required: no timeout flag set; client 3 is not skipped early.
- FRAME_DIVIDER_EN with FRAME_DIVIDE=3:
  - Stimulus: 6 startOfFrame pulses, all clients completing immediately.
  - Required: sequences start on pulses 3 and 6 only; frame_count=2; overrun_count=0.
